div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: DivArbiter

Interface
REQ-001 SHALL have parameter N, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port reqValid  input  [1:0]  per-requester request valid.
REQ-005 SHALL have port reqReady  output  [1:0]  per-requester accept; a request is accepted when reqValid[i] && reqReady[i].
REQ-006 SHALL have port reqOp  input  [1:0][1:0]  per-requester op: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have port reqDividend  input  [1:0][N-1:0]  per-requester dividend.
REQ-008 SHALL have port reqDivisor  input  [1:0][N-1:0]  per-requester divisor.
REQ-009 SHALL have port respValid  output  [1:0]  per-requester result valid.
REQ-010 SHALL have port respReady  input  [1:0]  per-requester result accept.
REQ-011 SHALL have port respResult  output  [N-1:0]  result, shared by both requesters, meaningful while any respValid bit is high.
REQ-012 SHALL have port stall  input  1  freeze all state, including the divider.
REQ-013 SHALL have port flush  input  1  abort the in-flight operation.

Function
REQ-014 SHALL implement FSM states Idle, Issue, Wait and Respond.
REQ-015 In Idle, reqReady SHALL be driven to the granted requester only, using round-robin; when both are valid, the one not granted last wins.
REQ-016 On accept, SHALL register op, operands and grant index, then go to Issue.
REQ-017 In Issue, SHALL pulse divider enable for one cycle with isSigned = ~op[0], then go to Wait.
REQ-018 In Wait, on divider done SHALL capture remnant if op[1] is set, else quotient, then go to Respond.
REQ-019 In Respond, respValid[grant] SHALL be held with a stable respResult until respReady[grant]; on that handshake SHALL go to Idle with no dead cycle, so a new accept is possible the next cycle.
REQ-020 Latency (accept cycle T to first respValid) SHALL be T+N+4 for a normal divide and T+3 for divisor==0 or for signed min/-1.
REQ-021 Results SHALL be RISC-V compliant:
- x/0: quotient all-ones, remainder x.
- signed min/-1: quotient min, remainder 0.
REQ-022 Stall SHALL hold every register, and reqReady and respValid SHALL be 0 while stall is high.
REQ-023 Flush SHALL take effect next edge: FSM to Idle, divider flushed, no response issued; round-robin pointer retained.
REQ-024 If flush and stall are simultaneous, flush SHALL win.
REQ-025 reqValid changes outside Idle SHALL be ignored; requests are never dropped, only left unaccepted.

Reset
REQ-026 Reset SHALL set the FSM to Idle, the round-robin pointer to requester 1 (so requester 0 wins first), reqReady=0, respValid=0, respResult=0, and clear all operand registers.
REQ-027 Reset mid-operation SHALL discard the in-flight op; the divider SHALL be held in reset via its rst input while rst is high.

Configuration
REQ-028 With DIV_ARBITER_RESULT_CACHE_EN defined, the block SHALL store the last completed {dividend, divisor, isSigned, quotient, remnant} plus a valid bit.
- An accepted request matching the stored operands and signedness SHALL skip Issue/Wait and reach Respond at T+1 with the selected half.
- The valid bit SHALL be cleared by reset only.
REQ-029 Without the macro, no cache storage SHALL exist and every request SHALL use the divider.

Structure
REQ-030 The op encoding enum and the FSM state enum SHALL live in the shared types package; isSigned and remainder-select derive from the op bits.
REQ-031 SHALL instantiate exactly one DivUnit sub-module, with its enable, stall, flush and rst driven by this block.

Verification
REQ-032 Req0 DIV 100/7 -> respValid[0] at T+36 (N=32), result 14.
REQ-033 Req0 REM 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFF; REMU with same operands -> 1.
REQ-034 Req1 DIVU 5/0 -> 0xFFFFFFFF at T+3; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-035 Both valid in the same cycle after reset -> req0 served first, req1 accepted the cycle after req0's response handshake; respReady held low for 5 cycles -> result stable.
REQ-036 Flush in Wait -> no respValid, reqReady the next cycle; a subsequent DIV 9/3 -> 3.
REQ-037 With the cache macro: DIV 100/7 then REM 100/7 -> second result 2 at T+1.

Source files
------------

// File: rtl/div_arbiter_pkg.sv
// Shared types for the two-requester divider arbiter.
// Holds the op encoding, the arbiter and divider FSM state enums and the
// helpers that derive signedness and remainder-select from the op bits.
package div_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    DV_IDLE = 2'b00,
    DV_PREP = 2'b01,
    DV_ITER = 2'b10,
    DV_DONE = 2'b11
  } dv_state_e;

  // Even op codes are the signed variants.
  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

  // Upper op bit selects the remainder half of the result.
  function automatic logic op_sel_rem(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_arbiter_div.sv
// Iterative restoring divider (DivUnit) with RISC-V special-case handling.
// Ports:
//   clk, rst        clock, async active-high reset
//   en_i            one-cycle start pulse, operands sampled on that edge
//   stall_i         freeze all state
//   flush_i         abandon the current divide (wins over stall)
//   signed_i        treat operands as two's complement
//   dividend_i      dividend
//   divisor_i       divisor
//   done_o          high for exactly one unstalled cycle when results are valid
//   quotient_o      quotient, valid with done_o
//   remnant_o       remainder, valid with done_o
// Timing: normal divide has done_o N+2 cycles after the start edge
// (1 prep + N iterations + done); x/0 and signed min/-1 report after 1.
module div_arbiter_div
  import div_arbiter_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         stall_i,
  input  logic         flush_i,
  input  logic         signed_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         done_o,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remnant_o
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

  dv_state_e      dstate_q, dstate_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [N-1:0]   div_q, div_d;
  logic           sgn_q, sgn_d;
  logic           negq_q, negq_d;
  logic           negr_q, negr_d;

  logic [N:0]     partial_c;
  logic [N:0]     diff_c;
  logic           ge_c;
  logic [N-1:0]   rem_n_c;
  logic [N-1:0]   quo_n_c;

  // One restoring step: shift in next dividend bit, subtract if it fits.
  assign partial_c = {rem_q, quo_q[N-1]};
  assign diff_c    = partial_c - {1'b0, div_q};
  assign ge_c      = ~diff_c[N];
  assign rem_n_c   = ge_c ? diff_c[N-1:0] : partial_c[N-1:0];
  assign quo_n_c   = {quo_q[N-2:0], ge_c};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dstate_q <= DV_IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      sgn_q    <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      dstate_q <= dstate_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      sgn_q    <= sgn_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

  // Next-state: flush beats stall beats start beats iteration.
  always_comb begin
    dstate_d = dstate_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    div_d    = div_q;
    sgn_d    = sgn_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    if (flush_i) begin
      dstate_d = DV_IDLE;
    end else if (!stall_i) begin
      if (en_i) begin
        quo_d = dividend_i;
        div_d = divisor_i;
        sgn_d = signed_i;
        rem_d = '0;
        if (divisor_i == '0) begin
          quo_d    = '1;
          rem_d    = dividend_i;
          dstate_d = DV_DONE;
        end else if (signed_i && dividend_i == MIN_V && divisor_i == '1) begin
          quo_d    = MIN_V;
          rem_d    = '0;
          dstate_d = DV_DONE;
        end else begin
          dstate_d = DV_PREP;
        end
      end else begin
        case (dstate_q)
          DV_PREP: begin
            // Work on magnitudes; signs are reapplied on the last step.
            negq_d   = sgn_q & (quo_q[N-1] ^ div_q[N-1]);
            negr_d   = sgn_q & quo_q[N-1];
            quo_d    = (sgn_q && quo_q[N-1]) ? -quo_q : quo_q;
            div_d    = (sgn_q && div_q[N-1]) ? -div_q : div_q;
            rem_d    = '0;
            cnt_d    = '0;
            dstate_d = DV_ITER;
          end
          DV_ITER: begin
            rem_d = rem_n_c;
            quo_d = quo_n_c;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
              quo_d    = negq_q ? -quo_n_c : quo_n_c;
              rem_d    = negr_q ? -rem_n_c : rem_n_c;
              dstate_d = DV_DONE;
            end
          end
          DV_DONE: dstate_d = DV_IDLE;
          default: dstate_d = DV_IDLE;
        endcase
      end
    end
  end

  assign done_o     = (dstate_q == DV_DONE);
  assign quotient_o = quo_q;
  assign remnant_o  = rem_q;

endmodule

// File: rtl/div_arbiter.sv
// Two-requester round-robin arbiter in front of a single iterative divider.
// Ports:
//   clk, rst      clock, async active-high reset
//   reqValid/reqReady/reqOp/reqDividend/reqDivisor   per-requester request
//   respValid/respReady   per-requester response handshake
//   respResult    shared result, held stable while a respValid bit is high
//   stall         freeze all state; reqReady/respValid forced low
//   flush         abort the in-flight op next edge (wins over stall)
// Optional: DIV_ARBITER_RESULT_CACHE_EN adds a one-entry result cache that
// lets a repeat of the last completed operands respond the cycle after accept.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        reqValid,
  output logic [1:0]        reqReady,
  input  logic [1:0][1:0]   reqOp,
  input  logic [1:0][N-1:0] reqDividend,
  input  logic [1:0][N-1:0] reqDivisor,
  output logic [1:0]        respValid,
  input  logic [1:0]        respReady,
  output logic [N-1:0]      respResult,
  input  logic              stall,
  input  logic              flush
);

  state_e        state_q, state_d;
  logic          rr_last_q, rr_last_d;
  logic          grant_q, grant_d;
  op_e           op_q, op_d;
  logic [N-1:0]  dividend_q, dividend_d;
  logic [N-1:0]  divisor_q, divisor_d;
  logic [N-1:0]  result_q, result_d;

  logic          run_c;
  logic          gnt_c;
  op_e           req_op_c;
  logic          div_en_c;
  logic          div_signed_c;
  logic          div_done;
  logic [N-1:0]  div_quo;
  logic [N-1:0]  div_rem;
  logic          cap_c;
  logic          hit_c;
  logic [N-1:0]  hit_res_c;

  // Handshakes are only offered on cycles where the edge will take effect.
  assign run_c        = ~stall & ~flush & ~rst;
  assign gnt_c        = (reqValid == 2'b11) ? ~rr_last_q : reqValid[1];
  assign req_op_c     = op_e'(reqOp[gnt_c]);
  assign div_signed_c = op_is_signed(op_q);
  assign cap_c        = (state_q == ST_WAIT) & run_c & div_done;

  div_arbiter_div #(.N(N)) u_div (
    .clk        (clk),
    .rst        (rst),
    .en_i       (div_en_c),
    .stall_i    (stall),
    .flush_i    (flush),
    .signed_i   (div_signed_c),
    .dividend_i (dividend_q),
    .divisor_i  (divisor_q),
    .done_o     (div_done),
    .quotient_o (div_quo),
    .remnant_o  (div_rem)
  );

`ifdef DIV_ARBITER_RESULT_CACHE_EN
  logic          c_valid_q;
  logic          c_signed_q;
  logic [N-1:0]  c_dvd_q;
  logic [N-1:0]  c_dvs_q;
  logic [N-1:0]  c_quo_q;
  logic [N-1:0]  c_rem_q;

  // Last completed divide; survives flush, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_valid_q  <= 1'b0;
      c_signed_q <= 1'b0;
      c_dvd_q    <= '0;
      c_dvs_q    <= '0;
      c_quo_q    <= '0;
      c_rem_q    <= '0;
    end else if (cap_c) begin
      c_valid_q  <= 1'b1;
      c_signed_q <= div_signed_c;
      c_dvd_q    <= dividend_q;
      c_dvs_q    <= divisor_q;
      c_quo_q    <= div_quo;
      c_rem_q    <= div_rem;
    end
  end

  assign hit_c     = c_valid_q
                   & (c_dvd_q == reqDividend[gnt_c])
                   & (c_dvs_q == reqDivisor[gnt_c])
                   & (c_signed_q == op_is_signed(req_op_c));
  assign hit_res_c = op_sel_rem(req_op_c) ? c_rem_q : c_quo_q;
`else
  assign hit_c     = 1'b0;
  assign hit_res_c = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_last_q  <= 1'b1;
      grant_q    <= 1'b0;
      op_q       <= OP_DIV;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      grant_q    <= grant_d;
      op_q       <= op_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
    end
  end

  // Arbitration FSM; stall holds everything because all updates need run_c.
  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    grant_d    = grant_q;
    op_d       = op_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    result_d   = result_q;
    reqReady   = 2'b00;
    respValid  = 2'b00;
    div_en_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_c && reqValid != 2'b00) begin
          reqReady[gnt_c] = 1'b1;
          op_d            = req_op_c;
          dividend_d      = reqDividend[gnt_c];
          divisor_d       = reqDivisor[gnt_c];
          grant_d         = gnt_c;
          rr_last_d       = gnt_c;
          if (hit_c) begin
            result_d = hit_res_c;
            state_d  = ST_RESP;
          end else begin
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (run_c) begin
          div_en_c = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cap_c) begin
          result_d = op_sel_rem(op_q) ? div_rem : div_quo;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (run_c) begin
          respValid[grant_q] = 1'b1;
          if (respReady[grant_q]) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  assign respResult = result_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter (N=32): directed RISC-V corner cases,
// round-robin, stall, flush, reset, then randomized ops against a plain
// arithmetic reference model. Honours DIV_ARBITER_RESULT_CACHE_EN.
module tb_div_arbiter;

  localparam int unsigned N = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        reqValid;
  logic [1:0]        reqReady;
  logic [1:0][1:0]   reqOp;
  logic [1:0][N-1:0] reqDividend;
  logic [1:0][N-1:0] reqDivisor;
  logic [1:0]        respValid;
  logic [1:0]        respReady;
  logic [N-1:0]      respResult;
  logic              stall;
  logic              flush;

  int checks = 0;
  int errors = 0;
  int last_gnt;
  logic        c_valid;
  logic [31:0] c_a, c_b;
  logic        c_s;

  always #5 clk = ~clk;

  div_arbiter #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .reqOp       (reqOp),
    .reqDividend (reqDividend),
    .reqDivisor  (reqDivisor),
    .respValid   (respValid),
    .respReady   (respReady),
    .respResult  (respResult),
    .stall       (stall),
    .flush       (flush)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics from plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!op[0] && a == MINV && b == 32'hFFFF_FFFF) begin
      q = MINV; r = 32'd0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int base_latency(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
`ifdef DIV_ARBITER_RESULT_CACHE_EN
    if (c_valid && c_a == a && c_b == b && c_s == !op[0]) return 1;
`endif
    if (b == 32'd0 || (!op[0] && a == MINV && b == 32'hFFFF_FFFF)) return 3;
    return N + 4;
  endfunction

  // One full transaction from Idle: accept, wait, optional hold, handshake.
  task automatic do_req(input int idx, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int st_at, input int st_len,
                        input int hold);
    int lat, base, exp_l, exp_g;
    logic [31:0] exp_r;
    logic got, quiet_bad, hold_bad;
    exp_r = ref_result(op, a, b);
    base  = base_latency(op, a, b);
    exp_l = base + ((st_len > 0 && st_at <= base) ? st_len : 0);
    reqOp[idx]       = op;
    reqDividend[idx] = a;
    reqDivisor[idx]  = b;
    reqValid[idx]    = 1'b1;
    #1;
    exp_g = (reqValid == 2'b11) ? (1 - last_gnt) : (reqValid[1] ? 1 : 0);
    check("grant", 32'(reqReady), 32'(1 << exp_g));
    if (reqReady[idx] !== 1'b1) begin
      reqValid[idx] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    reqValid[idx] = 1'b0;
    last_gnt = idx;
    lat = 1; got = 1'b0; quiet_bad = 1'b0;
    while (!got && lat <= exp_l + 10) begin
      stall = (st_len > 0 && lat >= st_at && lat < st_at + st_len);
      #1;
      if (respValid[idx] === 1'b1) got = 1'b1;
      else begin
        if (respValid !== 2'b00 || reqReady !== 2'b00) quiet_bad = 1'b1;
        @(posedge clk); #1;
        lat++;
      end
    end
    stall = 1'b0;
    check("latency", 32'(lat), 32'(exp_l));
    check("resp_valid", 32'(respValid), 32'(1 << idx));
    check("result", respResult, exp_r);
    check("busy_quiet", 32'(quiet_bad), 32'd0);
    hold_bad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (respValid !== 2'(1 << idx) || respResult !== exp_r) hold_bad = 1'b1;
    end
    if (hold > 0) check("hold_stable", 32'(hold_bad), 32'd0);
    respReady[idx] = 1'b1;
    @(posedge clk); #1;
    respReady[idx] = 1'b0;
    #1;
    check("post_handshake", 32'(respValid), 32'd0);
    c_valid = 1'b1; c_a = a; c_b = b; c_s = !op[0];
  endtask

  logic [31:0] ra, rb;
  logic [1:0]  rop;
  int ridx, sel, sa, sl, hh;

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    reqValid = 2'b11; respReady = 2'b00;
    reqOp = '0; reqDividend = '0; reqDivisor = '0;
    c_valid = 1'b0; c_a = '0; c_b = '0; c_s = 1'b0;
    last_gnt = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(reqReady), 32'd0);
    check("rst_resp_valid", 32'(respValid), 32'd0);
    check("rst_result", respResult, 32'd0);
    rst = 1'b0; reqValid = 2'b00;
    #1;
    check("idle_ready", 32'(reqReady), 32'd0);

    // Both valid after reset: requester 0 first, then 1 with no dead cycle.
    reqOp[1] = 2'b01; reqDividend[1] = 32'd5; reqDivisor[1] = 32'd0;
    reqOp[0] = 2'b00; reqDividend[0] = 32'd100; reqDivisor[0] = 32'd7;
    reqValid = 2'b11;
    #1;
    check("rr_first", 32'(reqReady), 32'b01);
    do_req(0, 2'b00, 32'd100, 32'd7, 0, 0, 5);
    reqOp[0] = 2'b10; reqDividend[0] = 32'hFFFF_FFF9; reqDivisor[0] = 32'd2;
    reqValid[0] = 1'b1;
    #1;
    check("rr_second", 32'(reqReady), 32'b10);
    do_req(1, 2'b01, 32'd5, 32'd0, 0, 0, 0);
    reqOp[1] = 2'b10; reqDividend[1] = 32'd5; reqDivisor[1] = 32'd0;
    reqValid[1] = 1'b1;
    #1;
    check("rr_third", 32'(reqReady), 32'b01);
    do_req(0, 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    do_req(1, 2'b10, 32'd5, 32'd0, 0, 0, 1);
    do_req(0, 2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    do_req(1, 2'b00, MINV, 32'hFFFF_FFFF, 0, 0, 0);

    // Stall mid-divide and stall over the response cycle.
    do_req(0, 2'b01, 32'd123456, 32'd789, 4, 3, 0);
    do_req(1, 2'b11, 32'd77, 32'd0, 3, 2, 0);

    // Flush in Wait: no response, immediately ready again.
    reqOp[0] = 2'b00; reqDividend[0] = 32'd1000; reqDivisor[0] = 32'd13;
    reqValid[0] = 1'b1;
    #1;
    check("flush_accept", 32'(reqReady), 32'b01);
    @(posedge clk); #1;
    reqValid[0] = 1'b0; last_gnt = 0;
    repeat (8) @(posedge clk);
    #1;
    flush = 1'b1;
    reqOp[0] = 2'b00; reqDividend[0] = 32'd9; reqDivisor[0] = 32'd3;
    reqValid[0] = 1'b1;
    #1;
    check("flush_ready_gated", 32'(reqReady), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush_ready_next", 32'(reqReady), 32'b01);
    check("flush_no_resp", 32'(respValid), 32'd0);
    do_req(0, 2'b00, 32'd9, 32'd3, 0, 0, 0);

    // Flush together with stall: flush wins.
    reqOp[1] = 2'b01; reqDividend[1] = 32'd4242; reqDivisor[1] = 32'd17;
    reqValid[1] = 1'b1;
    #1;
    @(posedge clk); #1;
    reqValid[1] = 1'b0; last_gnt = 1;
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1; stall = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; stall = 1'b0;
    reqValid[1] = 1'b1;
    #1;
    check("flush_stall_ready", 32'(reqReady), 32'b10);
    check("flush_stall_no_resp", 32'(respValid), 32'd0);
    do_req(1, 2'b11, 32'd4242, 32'd17, 0, 0, 0);

`ifdef DIV_ARBITER_RESULT_CACHE_EN
    do_req(0, 2'b00, 32'd100, 32'd7, 0, 0, 0);
    do_req(0, 2'b10, 32'd100, 32'd7, 0, 0, 0);
`endif

    // Randomized mix against the reference model.
    for (int i = 0; i < 16; i++) begin
      ridx = int'($urandom_range(0, 1));
      rop  = 2'($urandom_range(0, 3));
      sel  = int'($urandom_range(0, 5));
      case (sel)
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom; rb = 32'd0; end
        2: begin ra = MINV; rb = 32'hFFFF_FFFF; end
        3: begin ra = 32'($urandom_range(0, 1000)); rb = 32'($urandom_range(1, 50)); end
        4: begin
          ra = $urandom;
          rb = 32'($urandom_range(1, 100));
          if ($urandom_range(0, 1) == 1) rb = -rb;
        end
        default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
      endcase
      sl = (i % 3 == 0) ? int'($urandom_range(1, 2)) : 0;
      sa = int'($urandom_range(1, 4));
      hh = int'($urandom_range(0, 2));
      do_req(ridx, rop, ra, rb, sa, sl, hh);
    end

    // Reset in the middle of an operation.
    reqOp[0] = 2'b01; reqDividend[0] = 32'd12345; reqDivisor[0] = 32'd67;
    reqValid[0] = 1'b1;
    #1;
    @(posedge clk); #1;
    reqValid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    reqOp[1] = 2'b00; reqDividend[1] = 32'd50; reqDivisor[1] = 32'd5;
    reqOp[0] = 2'b00; reqDividend[0] = 32'd100; reqDivisor[0] = 32'd7;
    reqValid = 2'b11;
    #1;
    check("midrst_resp_valid", 32'(respValid), 32'd0);
    check("midrst_result", respResult, 32'd0);
    check("midrst_ready", 32'(reqReady), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    c_valid = 1'b0; last_gnt = 1;
    #1;
    check("midrst_rr", 32'(reqReady), 32'b01);
    do_req(0, 2'b00, 32'd100, 32'd7, 0, 0, 0);
    do_req(1, 2'b00, 32'd50, 32'd5, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
